hamming_decode_arbiter: RTL and testbench

//  Shares one combinational Hamming(7,4) decoder between two codeword requesters.
//  - Arbitrates round-robin and registers the winning codeword.
//  - Drives the codeword onto the decoder, captures the decoded nibble and error flag.
//  - Returns the result on one response channel, tagged with the requester id.
//  - Keeps a saturating decode-error count for each requester.

---
 rtl/hamming_decode_arbiter_if.sv | 35 +++
 rtl/hamming_decode_arbiter.sv | 114 +++++++++++
 tb/tb_hamming_decode_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_decode_arbiter_if.sv
// rtl/hamming_decode_arbiter_if.sv - requester, decoder, response and counter signals of hamming_decode_arbiter
interface hamming_decode_arbiter_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 req0_valid;
  logic [6:0]           req0_cw;
  logic                 req0_ready;
  logic                 req1_valid;
  logic [6:0]           req1_cw;
  logic                 req1_ready;
  logic [6:0]           dec_codeword;
  logic [3:0]           dec_data;
  logic                 dec_error;
  logic                 rsp_valid;
  logic                 rsp_id;
  logic [3:0]           rsp_data;
  logic                 rsp_err;
  logic                 rsp_ready;
  logic                 err_clr;
  logic [ERR_CNT_W-1:0] err_cnt0;
  logic [ERR_CNT_W-1:0] err_cnt1;
  logic                 busy;

  modport slave (
    input  req0_valid, req0_cw, req1_valid, req1_cw, dec_data, dec_error, rsp_ready, err_clr,
    output req0_ready, req1_ready, dec_codeword, rsp_valid, rsp_id, rsp_data, rsp_err,
           err_cnt0, err_cnt1, busy
  );

  modport master (
    output req0_valid, req0_cw, req1_valid, req1_cw, dec_data, dec_error, rsp_ready, err_clr,
    input  req0_ready, req1_ready, dec_codeword, rsp_valid, rsp_id, rsp_data, rsp_err,
           err_cnt0, err_cnt1, busy
  );
endinterface

// File: rtl/hamming_decode_arbiter.sv
// rtl/hamming_decode_arbiter.sv - round-robin sharing of one combinational Hamming(7,4) decoder
module hamming_decode_arbiter #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  hamming_decode_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [6:0]           cw_q, cw_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic [3:0]           data_q, data_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt0_q, cnt0_d;
  logic [ERR_CNT_W-1:0] cnt1_q, cnt1_d;
  logic                 any_valid;
  logic                 grant_id;

  // A lone requester always wins; a tie goes to whoever did not win last.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant_id  = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  end

  always_comb begin
    state_d          = state_q;
    cw_d             = cw_q;
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    data_d           = data_q;
    err_d            = err_q;
    cnt0_d           = cnt0_q;
    cnt1_d           = cnt1_q;
    bus.req0_ready   = 1'b0;
    bus.req1_ready   = 1'b0;
    bus.dec_codeword = 7'h00;
    bus.rsp_valid    = 1'b0;
    bus.rsp_id       = 1'b0;
    bus.rsp_data     = 4'h0;
    bus.rsp_err      = 1'b0;
    bus.busy         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // No acceptance while reset is held, so nothing is lost across it.
        if (any_valid && !reset) begin
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          cw_d           = grant_id ? bus.req1_cw : bus.req0_cw;
          owner_d        = grant_id;
          last_grant_d   = grant_id;
          state_d        = DECODE;
        end
      end
      DECODE: begin
        bus.dec_codeword = cw_q;
        data_d           = bus.dec_data;
        err_d            = bus.dec_error;
        if (bus.dec_error) begin
          if (!owner_q && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + 1'b1;
          if (owner_q && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + 1'b1;
        end
        state_d = RESPOND;
      end
      RESPOND: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = owner_q;
        bus.rsp_data  = data_q;
        bus.rsp_err   = err_q;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.err_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cw_q         <= 7'h00;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      data_q       <= 4'h0;
      err_q        <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      cw_q         <= cw_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      err_q        <= err_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign bus.err_cnt0 = cnt0_q;
  assign bus.err_cnt1 = cnt1_q;
endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// tb/tb_hamming_decode_arbiter.sv - self-checking bench for hamming_decode_arbiter
module tb_hamming_decode_arbiter;
  localparam int W = 2;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hamming_decode_arbiter_if #(.ERR_CNT_W(W)) bus ();
  hamming_decode_arbiter #(.ERR_CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;

  bit         stub_forced = 1'b0;
  logic [3:0] force_data = 4'h0;
  logic       force_err = 1'b0;

  // Hamming(7,4): bit i-1 is position i; parity at 1,2,4; data at 3,5,6,7.
  function automatic logic [4:0] ref_decode(input logic [6:0] cw);
    int syn;
    logic [6:0] c;
    syn = 0;
    c = cw;
    for (int p = 1; p <= 7; p++) if (c[p-1]) syn = syn ^ p;
    if (syn != 0) c[syn-1] = ~c[syn-1];
    return {syn != 0, c[6], c[5], c[4], c[2]};
  endfunction

  assign {bus.dec_error, bus.dec_data} = stub_forced ? {force_err, force_data}
                                                     : ref_decode(bus.dec_codeword);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_cw = 7'h00;
    bus.req1_valid = 1'b0; bus.req1_cw = 7'h00;
    bus.rsp_ready = 1'b0;  bus.err_clr = 1'b0;
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.req0_ready, bus.req1_ready, bus.dec_codeword, bus.rsp_valid, bus.rsp_id,
            bus.rsp_data, bus.rsp_err, bus.err_cnt0, bus.err_cnt1, bus.busy};
  endfunction

  task automatic run_one(input bit id, input logic [6:0] cw,
                         output logic rid, output logic [3:0] d, output logic e);
    int n;
    rid = 1'b0; d = 4'h0; e = 1'b0;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_cw = cw; end
    else    begin bus.req0_valid = 1'b1; bus.req0_cw = cw; end
    bus.rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 10) begin step(); @(negedge clk); n++; end
    chk("accept_bound", n < 10, 1);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 10) begin step(); @(negedge clk); n++; end
    chk("rsp_bound", n < 10, 1);
    rid = bus.rsp_id; d = bus.rsp_data; e = bus.rsp_err;
    step();
  endtask

  typedef struct {
    logic [6:0] cw;
    logic [3:0] data;
    logic       err;
  } vec_t;

  typedef struct {
    bit         id;
    logic [6:0] cw;
    int         t;
  } pend_t;

  initial begin
    vec_t       vecs[7];
    pend_t      q[$];
    pend_t      p;
    int         mcnt[2];
    logic       rid, e, gid, m_last, rsp_seen;
    logic [3:0] d;
    logic [4:0] exp_de;
    logic [6:0] cw0[4], cw1[4];
    logic [6:0] hold_cw[2];
    bit         hold[2];
    logic [5:0] snap;
    int         i0, i1, g;

    vecs[0] = '{7'h00, 4'h0, 1'b0};
    vecs[1] = '{7'h7F, 4'hF, 1'b0};
    vecs[2] = '{7'h07, 4'h1, 1'b0};
    vecs[3] = '{7'h47, 4'h1, 1'b1};
    vecs[4] = '{7'h01, 4'h0, 1'b1};
    vecs[5] = '{7'h4B, 4'h8, 1'b0};
    vecs[6] = '{7'h4F, 4'h8, 1'b1};

    idle_inputs();
    reset = 1'b1;
    do_reset();
    @(negedge clk);
    chk("reset_outputs", all_outs(), 0);

    // Single request, forced decoder output, latency T -> T+2.
    stub_forced = 1'b1; force_data = 4'hB; force_err = 1'b0;
    step();
    bus.req0_valid = 1'b1; bus.req0_cw = 7'h66; bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t1_ready0", {bus.req0_ready, bus.req1_ready}, 2'b10);
    step();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_decode", {bus.dec_codeword, bus.rsp_valid, bus.busy}, {7'h66, 1'b0, 1'b1});
    step();
    @(negedge clk);
    chk("t1_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err}, {1'b1, 1'b0, 4'hB, 1'b0});
    chk("t1_cnt0", bus.err_cnt0, 0);
    step();

    // Table of codewords through the real Hamming stub.
    stub_forced = 1'b0;
    do_reset();
    mcnt[0] = 0; mcnt[1] = 0;
    for (int i = 0; i < 7; i++) begin
      run_one(i[0], vecs[i].cw, rid, d, e);
      chk("vec_id", rid, i[0]);
      chk("vec_data", d, vecs[i].data);
      chk("vec_err", e, vecs[i].err);
      if (vecs[i].err && mcnt[i[0]] < CMAX) mcnt[i[0]]++;
    end
    chk("vec_cnt0", bus.err_cnt0, mcnt[0]);
    chk("vec_cnt1", bus.err_cnt1, mcnt[1]);

    // Continuous dual requests: grants must alternate starting with 0.
    do_reset();
    cw0 = '{7'h07, 7'h7F, 7'h47, 7'h4B};
    cw1 = '{7'h01, 7'h4F, 7'h00, 7'h33};
    i0 = 0; i1 = 0; g = 0;
    q.delete();
    bus.rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && (g < 8 || q.size() > 0); cyc++) begin
      bus.req0_valid = (i0 < 4); bus.req0_cw = cw0[i0 & 3];
      bus.req1_valid = (i1 < 4); bus.req1_cw = cw1[i1 & 3];
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        gid = bus.req1_ready;
        chk("fair_grant", gid, g % 2);
        q.push_back('{gid, gid ? cw1[i1 & 3] : cw0[i0 & 3], cyc});
        if (gid) i1++; else i0++;
        g++;
      end
      if (bus.rsp_valid && q.size() > 0) begin
        p = q.pop_front();
        exp_de = ref_decode(p.cw);
        chk("fair_rsp", {bus.rsp_id, bus.rsp_err, bus.rsp_data}, {p.id, exp_de});
      end
      step();
    end
    chk("fair_count", g, 8);
    chk("fair_drain", q.size(), 0);

    // Response stall: fields frozen, no acceptance, then release.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_cw = 7'h47;
    bus.req1_valid = 1'b1; bus.req1_cw = 7'h7F;
    @(negedge clk);
    chk("stall_grant", {bus.req0_ready, bus.req1_ready}, 2'b10);
    step(); bus.req0_valid = 1'b0;
    step();
    @(negedge clk);
    snap = {bus.rsp_valid, bus.rsp_id, bus.rsp_data};
    chk("stall_first", {snap, bus.rsp_err}, {1'b1, 1'b0, 4'h1, 1'b1});
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      chk("stall_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err}, {snap, 1'b1});
      chk("stall_ready", {bus.req0_ready, bus.req1_ready, bus.busy}, 3'b001);
    end
    step();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", bus.rsp_valid, 1);
    step();
    @(negedge clk);
    chk("stall_next", {bus.rsp_valid, bus.req0_ready, bus.req1_ready}, 3'b001);
    step();
    bus.req1_valid = 1'b0;

    // Saturation on requester 1 with forced errors.
    do_reset();
    stub_forced = 1'b1; force_err = 1'b1; force_data = 4'h5;
    for (int k = 0; k < 5; k++) begin
      run_one(1'b1, 7'(k), rid, d, e);
      chk("sat_cnt1", bus.err_cnt1, (k + 1 < CMAX) ? k + 1 : CMAX);
      chk("sat_cnt0", bus.err_cnt0, 0);
    end

    // err_clr in the DECODE cycle beats the increment.
    bus.req1_valid = 1'b1; bus.req1_cw = 7'h15; bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("clr_accept", bus.req1_ready, 1);
    step();
    bus.req1_valid = 1'b0; bus.err_clr = 1'b1;
    @(negedge clk);
    chk("clr_decode", {bus.dec_codeword, bus.dec_error}, {7'h15, 1'b1});
    step();
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnts", {bus.rsp_valid, bus.err_cnt0, bus.err_cnt1}, {1'b1, 4'h0});
    step();

    // Reset during DECODE drops the in-flight response.
    do_reset();
    run_one(1'b0, 7'h11, rid, d, e);
    chk("rst_pre_cnt0", bus.err_cnt0, 1);
    stub_forced = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_cw = 7'h7F;
    @(negedge clk);
    chk("rst_accept", bus.req0_ready, 1);
    step();
    bus.req0_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", all_outs(), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("rst_no_rsp", {bus.rsp_valid, bus.busy}, 2'b00);
    end

    // Random traffic against a queue-based reference.
    do_reset();
    q.delete();
    mcnt[0] = 0; mcnt[1] = 0;
    m_last = 1'b1; rsp_seen = 1'b0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    hold_cw[0] = 7'h00; hold_cw[1] = 7'h00;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (cyc >= 600 && q.size() == 0 && !hold[0] && !hold[1]) break;
      for (int r = 0; r < 2; r++)
        if (!hold[r] && cyc < 600 && $urandom_range(2) == 0) begin
          hold[r] = 1'b1;
          hold_cw[r] = 7'($urandom_range(127));
        end
      bus.req0_valid = hold[0]; bus.req0_cw = hold_cw[0];
      bus.req1_valid = hold[1]; bus.req1_cw = hold_cw[1];
      bus.rsp_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        gid = bus.req1_ready;
        chk("rnd_grant", {bus.req0_ready & bus.req1_ready, gid},
            {1'b0, (hold[0] && hold[1]) ? ~m_last : hold[1]});
        chk("rnd_in_flight", q.size(), 0);
        q.push_back('{gid, hold_cw[gid], cyc});
        m_last = gid;
        hold[gid] = 1'b0;
      end
      if (bus.rsp_valid) begin
        if (q.size() == 0) chk("rnd_spurious_rsp", 1, 0);
        else begin
          p = q[0];
          if (!rsp_seen) chk("rnd_latency", cyc - p.t, 2);
          rsp_seen = 1'b1;
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            rsp_seen = 1'b0;
            exp_de = ref_decode(p.cw);
            chk("rnd_rsp", {bus.rsp_id, bus.rsp_err, bus.rsp_data}, {p.id, exp_de});
            if (exp_de[4] && mcnt[p.id] < CMAX) mcnt[p.id]++;
            chk("rnd_cnts", {bus.err_cnt0, bus.err_cnt1}, {2'(mcnt[0]), 2'(mcnt[1])});
          end
        end
      end
      step();
    end
    chk("rnd_drained", {q.size() == 0, hold[0], hold[1]}, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
